// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam int unsigned INST_BYTES = 4;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instruction} pairs; flush empties it in one cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             pop_ok;
    logic             push_ok;

    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != FULL) || pop_ok);

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok && !reset && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns fetch_pc, drives the ROM address and queues fetched words.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        misalign,
    output logic [1:0]  fetch_state
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_addr_width
        $error("inst_fetch_ctrl: ADDR_WIDTH must be within 1..30");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("inst_fetch_ctrl: DEPTH must be a power of two, at least 2");
    end

    fetch_state_e   state;
    logic [31:0]    fetch_pc;
    logic [CW-1:0]  count;
    logic [63:0]    head_data;
    logic           pop;
    logic           push;

    // A pop coinciding with a redirect is dropped along with the rest of the queue.
    assign pop  = inst_valid && inst_ready && !redirect_valid;
    assign push = (state == RUN) && !redirect_valid && ((count != FULL) || pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BOOT;
        end else if (redirect_valid) begin
            state <= RUN;
        end else begin
            state <= halt ? HALT : RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= align_pc(redirect_pc);
        end else if (push) begin
            fetch_pc <= fetch_pc + 32'(INST_BYTES);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            misalign <= 1'b0;
        end else begin
            misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .pop       (pop),
        .push_data ({fetch_pc, rom_data}),
        .head_data (head_data),
        .count     (count)
    );

    assign rom_addr    = fetch_pc;
    assign inst_valid  = (count != '0);
    assign inst_pc     = head_data[63:32];
    assign inst_out    = head_data[31:0];
    assign fetch_state = state;

endmodule
